// File: rtl/data_mem_mmio.sv
// Data-side memory responder: word RAM with byte strobes plus an MMIO window
// holding a console TX FIFO, a free-running cycle counter and a TOHOST halt register.
module data_mem_mmio #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_mem_addr,
  input  logic        data_mem_read,
  input  logic [3:0]  data_mem_write,
  input  logic [31:0] data_mem_data_w,
  output logic [31:0] data_mem_data_r,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          FPW       = $clog2(FIFO_DEPTH);
  localparam int          CW        = FPW + 1;
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0] mem [DEPTH_WORDS];
  logic [7:0]  fifo_q [FIFO_DEPTH];

  logic [FPW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;
  logic [31:0]    cycle_q, cycle_d;
  logic           halt_q, halt_d;
  logic [31:0]    halt_code_q, halt_code_d;

  logic           ram_sel, mmio_sel, wr_any;
  logic [1:0]     reg_sel;
  logic [AW-1:0]  ram_idx;
  logic           fifo_empty, fifo_full, pop, push_req, push_ok;
  logic [31:0]    status, rd_val;

  always_comb begin
    ram_sel    = ({1'b0, data_mem_addr} < RAM_BYTES);
    mmio_sel   = (data_mem_addr[31:4] == MMIO_BASE[31:4]);
    reg_sel    = data_mem_addr[3:2];
    ram_idx    = data_mem_addr[AW+1:2];
    wr_any     = |data_mem_write;
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    pop        = !fifo_empty && con_ready;
    push_req   = mmio_sel && (reg_sel == 2'd0) && data_mem_write[0];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok    = push_req && (!fifo_full || pop);
  end

  always_comb begin
    head_d      = pop ? head_q + FPW'(1) : head_q;
    tail_d      = push_ok ? tail_q + FPW'(1) : tail_q;
    count_d     = count_q + CW'(push_ok) - CW'(pop);
    ovf_d       = ovf_q;
    if (mmio_sel && (reg_sel == 2'd1) && wr_any)
      ovf_d = 1'b0;
    else if (push_req && fifo_full && !pop)
      ovf_d = 1'b1;
    cycle_d     = cycle_q + 32'd1;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    if (mmio_sel && (reg_sel == 2'd3) && wr_any && (data_mem_data_w != 32'h0) && !halt_q) begin
      halt_d      = 1'b1;
      halt_code_d = data_mem_data_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      cycle_q     <= 32'h0;
      halt_q      <= 1'b0;
      halt_code_q <= 32'h0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      cycle_q     <= cycle_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
    end
  end

  // Storage arrays are not reset; stores during reset are discarded.
  always_ff @(posedge clk) begin
    if (!rst && ram_sel) begin
      for (int i = 0; i < 4; i++)
        if (data_mem_write[i]) mem[ram_idx][8*i +: 8] <= data_mem_data_w[8*i +: 8];
    end
    if (!rst && push_ok)
      fifo_q[tail_q] <= data_mem_data_w[7:0];
  end

  always_comb begin
    status        = 32'h0;
    status[31]    = ovf_q;
    status[9]     = fifo_empty;
    status[8]     = fifo_full;
    status[7:0]   = 8'(count_q);
    rd_val        = 32'h0;
    if (ram_sel)
      rd_val = mem[ram_idx];
    else if (mmio_sel) begin
      case (reg_sel)
        2'd1:    rd_val = status;
        2'd2:    rd_val = cycle_q;
        2'd3:    rd_val = halt_code_q;
        default: rd_val = 32'h0;
      endcase
    end
    data_mem_data_r = data_mem_read ? rd_val : 32'h0;
    con_valid       = !fifo_empty;
    con_data        = fifo_empty ? 8'h00 : fifo_q[head_q];
    halt            = halt_q;
    halt_code       = halt_code_q;
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: RAM lanes, console FIFO, cycle counter,
// TOHOST halt and decode boundaries, checked with immediate assertions.
module tb_data_mem_mmio;

  localparam logic [31:0] MB    = 32'hFFFF_0000;
  localparam logic [31:0] TX    = MB + 32'h0;
  localparam logic [31:0] STAT  = MB + 32'h4;
  localparam logic [31:0] CYC   = MB + 32'h8;
  localparam logic [31:0] TOH   = MB + 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        rd_en;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        halt;
  logic [31:0] halt_code;

  int total = 0;
  int bad   = 0;
  logic [31:0] v;
  logic [7:0]  exp_q [8];

  data_mem_mmio dut (
    .clk            (clk),
    .rst            (rst),
    .data_mem_addr  (addr),
    .data_mem_read  (rd_en),
    .data_mem_write (strb),
    .data_mem_data_w(wdata),
    .data_mem_data_r(rdata),
    .con_valid      (con_valid),
    .con_data       (con_data),
    .con_ready      (con_ready),
    .halt           (halt),
    .halt_code      (halt_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    addr = 32'h0; rd_en = 1'b0; strb = 4'h0; wdata = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    addr = a; rd_en = 1'b0; strb = s; wdata = d;
    step();
    idle();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] val);
    addr = a; rd_en = 1'b1; strb = 4'h0;
    #1 val = rdata;
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1; con_ready = 1'b0;
    step(); step();
    rst = 1'b0;

    // reset state, first cycle after release
    chk("rst_con_valid", 32'(con_valid), 32'h0);
    chk("rst_con_data", 32'(con_data), 32'h0);
    chk("rst_halt", 32'(halt), 32'h0);
    chk("rst_halt_code", halt_code, 32'h0);
    rd(CYC, v);  chk("cycle_k0", v, 32'd0);
    rd(STAT, v); chk("rst_status", v, 32'h0000_0200);
    repeat (5) step();
    rd(CYC, v);  chk("cycle_k5", v, 32'd5);

    // byte-lane stores
    wr(32'h10, 4'hF, 32'h1122_3344);
    wr(32'h10, 4'b0101, 32'hAABB_CCDD);
    rd(32'h10, v); chk("lane_merge", v, 32'h11BB_33DD);
    addr = 32'h10; rd_en = 1'b0;
    #1 chk("read_gated", rdata, 32'h0);
    // same-cycle read and write returns the old word
    addr = 32'h10; rd_en = 1'b1; strb = 4'hF; wdata = 32'h0;
    #1 chk("rw_old_value", rdata, 32'h11BB_33DD);
    step(); idle();
    rd(32'h10, v); chk("rw_new_value", v, 32'h0);

    // console backpressure: nine pushes into an eight-deep FIFO
    con_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(TX, 4'h1, 32'h41 + i);
    rd(STAT, v); chk("bp_status", v, 32'h8000_0108);
    step(); step();
    chk("bp_hold_data", 32'(con_data), 32'h41);
    wr(STAT, 4'h2, 32'h0);
    rd(STAT, v); chk("ovf_clear", v, 32'h0000_0108);
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(con_valid), 32'h1);
      chk("drain_data", 32'(con_data), 32'h41 + i);
      step();
    end
    chk("drain_done_valid", 32'(con_valid), 32'h0);
    chk("drain_done_data", 32'(con_data), 32'h0);
    con_ready = 1'b0;

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) wr(TX, 4'h1, 32'h50 + i);
    addr = TX; strb = 4'h1; wdata = 32'h5A; con_ready = 1'b1;
    step(); idle(); con_ready = 1'b0;
    rd(STAT, v); chk("fullpp_status", v, 32'h0000_0108);
    exp_q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h5A};
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("fullpp_data", 32'(con_data), 32'(exp_q[i]));
      step();
    end
    chk("fullpp_empty", 32'(con_valid), 32'h0);

    // push into empty FIFO while sink is ready: only the push happens
    wr(TX, 4'h1, 32'h77);
    chk("empty_pp_valid", 32'(con_valid), 32'h1);
    chk("empty_pp_data", 32'(con_data), 32'h77);
    step();
    chk("empty_pp_popped", 32'(con_valid), 32'h0);
    con_ready = 1'b0;

    // decode edges
    wr(32'h0, 4'hF, 32'hCAFE_BABE);
    wr(32'h0000_1000, 4'hF, 32'h1234_5678);
    rd(32'h0000_1000, v); chk("oob_ram_read", v, 32'h0);
    rd(32'h0, v);         chk("oob_ram_alias", v, 32'hCAFE_BABE);
    wr(MB + 32'h10, 4'hF, 32'h0000_0041);
    rd(MB + 32'h10, v);   chk("oob_mmio_read", v, 32'h0);
    rd(32'h0, v);         chk("oob_mmio_ram", v, 32'hCAFE_BABE);
    rd(STAT, v);          chk("oob_mmio_status", v, 32'h0000_0200);
    chk("oob_mmio_halt", 32'(halt), 32'h0);

    // cycle counter wrap
    force dut.cycle_q = 32'hFFFF_FFFF;
    rd(CYC, v); chk("cycle_max", v, 32'hFFFF_FFFF);
    release dut.cycle_q;
    step();
    rd(CYC, v); chk("cycle_wrap", v, 32'h0);

    // TOHOST
    wr(TOH, 4'hF, 32'h0);
    chk("toh_zero_halt", 32'(halt), 32'h0);
    wr(TOH, 4'hF, 32'h1);
    chk("toh_halt", 32'(halt), 32'h1);
    chk("toh_code", halt_code, 32'h1);
    wr(TOH, 4'hF, 32'h3);
    chk("toh_sticky_code", halt_code, 32'h1);
    rd(TOH, v); chk("toh_read", v, 32'h1);

    // reset mid-operation, with a push presented during reset
    wr(TX, 4'h1, 32'h33);
    chk("pre_rst_valid", 32'(con_valid), 32'h1);
    rst = 1'b1; addr = TX; strb = 4'h1; wdata = 32'h99;
    step();
    rst = 1'b0; idle();
    chk("mid_rst_halt", 32'(halt), 32'h0);
    chk("mid_rst_code", halt_code, 32'h0);
    chk("mid_rst_valid", 32'(con_valid), 32'h0);
    chk("mid_rst_data", 32'(con_data), 32'h0);
    rd(STAT, v); chk("mid_rst_status", v, 32'h0000_0200);
    rd(CYC, v);  chk("mid_rst_cycle", v, 32'h0);
    rd(32'h0, v); chk("mid_rst_ram_kept", v, 32'hCAFE_BABE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
